cpu_program_loader: RTL and testbench

Streams a program image into the CPU's instruction memory and holds the CPU in reset until the image is complete. It is the write side of the instruction fetch path: the CPU reads IR from byte address PC, with PC advancing by 2, and this block writes words at those same addresses. Loading ends when the halt word 0xFFFF has been written. The block then releases the CPU. The testbench and top-level use it in place of hard-coded memory initialisation.

---
 rtl/cpu_program_loader.sv | 127 ++++++++++++
 tb/tb_cpu_program_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_loader.sv
// cpu_program_loader
//
// Streams a program image into the CPU instruction memory and keeps the CPU
// in reset until the halt word has been written. Word k of the image is
// written at byte address 2k, which is where the CPU fetches it (PC steps by
// 2 and starts at 0). If memory fills up without a halt word, the block stops
// in an error state with the CPU still held.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-high reset
//   start      - one-cycle pulse that begins or restarts a load
//   in_valid   - source presents a word on in_data
//   in_data    - instruction word from the source
//   in_ready   - loader accepts a word this cycle
//   mem_we     - instruction memory write strobe (one cycle per word)
//   mem_addr   - even byte address of the write
//   mem_wdata  - write data
//   cpu_hold   - CPU reset; 1 = CPU held
//   done       - program loaded, CPU released
//   error      - memory filled without a halt word
//   word_count - words accepted in the current load (saturates at MAX_WORDS)

module cpu_program_loader #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 16,
    parameter int                 MAX_WORDS = 32,
    parameter logic [DATA_W-1:0]  HALT_WORD = 16'hFFFF,
    localparam int                CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [CW-1:0]     word_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FINISH,
        RUN,
        ERR
    } state_t;

    state_t state;

    // NOTE: every register here is written with <= so all outputs update
    // together from the values seen at the same clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            // NOTE: the strobe defaults low each cycle so it can only be high
            // for the single cycle after an accepted word.
            mem_we <= 1'b0;

            case (state)
                IDLE, RUN, ERR: begin
                    // Memory contents are left alone; a new image simply
                    // overwrites from address 0.
                    if (start) begin
                        state      <= LOAD;
                        in_ready   <= 1'b1;
                        word_count <= '0;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        cpu_hold   <= 1'b1;
                    end
                end

                LOAD: begin
                    // start is deliberately ignored here.
                    if (in_valid && in_ready) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'({word_count, 1'b0});
                        mem_wdata <= in_data;
                        if (word_count != CW'(MAX_WORDS))
                            word_count <= word_count + 1'b1;

                        // The halt word wins even when it lands in the last slot.
                        if (in_data == HALT_WORD) begin
                            state    <= FINISH;
                            in_ready <= 1'b0;
                        end else if (word_count == CW'(MAX_WORDS - 1)) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end
                    end
                end

                FINISH: begin
                    // The halt word is being written this cycle; release the
                    // CPU on the next one so it never fetches a stale word.
                    state    <= RUN;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b1;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader
//
// Drives two loader instances: one with the default 32-word memory and one
// with MAX_WORDS=4 for the overflow / last-slot cases. Only one instance is
// active at a time; the other sees start and in_valid held low. Expected
// writes are queued as words are driven and popped by a write monitor.

module tb_cpu_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        use4;

    int checks = 0;
    int errors = 0;
    int exp_count;

    logic [31:0] q32[$];
    logic [31:0] q4[$];

    always #5 clock = ~clock;

    // 32-word instance
    logic        start32, valid32;
    logic        rdy32, we32, hold32, done32, err32;
    logic [15:0] addr32, wdata32;
    logic [5:0]  wc32;

    // 4-word instance
    logic        start4, valid4;
    logic        rdy4, we4, hold4, done4, err4;
    logic [15:0] addr4, wdata4;
    logic [2:0]  wc4;

    assign start32 = start & ~use4;
    assign valid32 = in_valid & ~use4;
    assign start4  = start & use4;
    assign valid4  = in_valid & use4;

    cpu_program_loader dut32 (
        .clock(clock), .reset(reset), .start(start32),
        .in_valid(valid32), .in_data(in_data), .in_ready(rdy32),
        .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32),
        .cpu_hold(hold32), .done(done32), .error(err32), .word_count(wc32)
    );

    cpu_program_loader #(.MAX_WORDS(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4),
        .in_valid(valid4), .in_data(in_data), .in_ready(rdy4),
        .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
        .cpu_hold(hold4), .done(done4), .error(err4), .word_count(wc4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the next queued {addr, data}.
    always @(negedge clock) begin
        logic [31:0] e;
        if (we32 !== 1'b0) begin
            if (q32.size() == 0) check("w32_spurious_we", {31'd0, we32}, 32'd0);
            else begin
                e = q32.pop_front();
                check("w32_write", {addr32, wdata32}, e);
            end
        end
        if (we4 !== 1'b0) begin
            if (q4.size() == 0) check("w4_spurious_we", {31'd0, we4}, 32'd0);
            else begin
                e = q4.pop_front();
                check("w4_write", {addr4, wdata4}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Present one word for one cycle; it is accepted at the next rising edge.
    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        if (use4) q4.push_back({16'(2 * exp_count), w});
        else      q32.push_back({16'(2 * exp_count), w});
        exp_count++;
        @(negedge clock);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check32(input string tag, input logic rdy, input logic hold,
                           input logic dn, input logic er, input logic [5:0] wc);
        check({tag, "_in_ready"}, {31'd0, rdy32}, {31'd0, rdy});
        check({tag, "_cpu_hold"}, {31'd0, hold32}, {31'd0, hold});
        check({tag, "_done"}, {31'd0, done32}, {31'd0, dn});
        check({tag, "_error"}, {31'd0, err32}, {31'd0, er});
        check({tag, "_word_count"}, {26'd0, wc32}, {26'd0, wc});
    endtask

    task automatic check4(input string tag, input logic rdy, input logic hold,
                          input logic dn, input logic er, input logic [2:0] wc);
        check({tag, "_in_ready"}, {31'd0, rdy4}, {31'd0, rdy});
        check({tag, "_cpu_hold"}, {31'd0, hold4}, {31'd0, hold});
        check({tag, "_done"}, {31'd0, done4}, {31'd0, dn});
        check({tag, "_error"}, {31'd0, err4}, {31'd0, er});
        check({tag, "_word_count"}, {29'd0, wc4}, {29'd0, wc});
    endtask

    logic [15:0] prog [8] = '{16'h710F, 16'h26C0, 16'h1780, 16'h0BC0,
                              16'h4B40, 16'h6E40, 16'h6B40, 16'hFFFF};

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 'x;
        use4     = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state of both instances
        check32("rst32", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        check("rst32_mem", {15'd0, we32, addr32}, 32'd0);
        check("rst32_wdata", {16'd0, wdata32}, 32'd0);
        check4("rst4", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        check("rst4_mem", {15'd0, we4, addr4}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check32("idle32", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);

        // 1. Nominal load, in_valid held high
        exp_count = 0;
        pulse_start();
        check32("s1_start", 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 8; i++) send(prog[i]);
        in_valid = 1'b0;
        in_data  = 'x;
        check32("s1_finish", 1'b0, 1'b1, 1'b0, 1'b0, 6'd8);
        @(negedge clock);
        check32("s1_run", 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
        check("s1_pending", q32.size(), 32'd0);

        // 2. Same program with bubbles, restarted from RUN
        exp_count = 0;
        pulse_start();
        check32("s2_start", 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 8; i++) begin
            send(prog[i]);
            if (i < 7) idle_cycle();
        end
        in_valid = 1'b0;
        in_data  = 'x;
        check32("s2_finish", 1'b0, 1'b1, 1'b0, 1'b0, 6'd8);
        @(negedge clock);
        check32("s2_run", 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
        check("s2_pending", q32.size(), 32'd0);

        // 3. Overflow on the 4-word instance
        use4      = 1'b1;
        exp_count = 0;
        pulse_start();
        check4("s3_start", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        send(16'h4444);
        in_valid = 1'b0;
        in_data  = 'x;
        check4("s3_err", 1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clock);
        check4("s3_after_extra", 1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
        check("s3_pending", q4.size(), 32'd0);

        // 4. Halt word in the last slot
        exp_count = 0;
        pulse_start();
        send(16'h1111);
        send(16'h2222);
        send(16'h3333);
        send(16'hFFFF);
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clock);
        check4("s4_run", 1'b0, 1'b0, 1'b1, 1'b0, 3'd4);
        check("s4_pending", q4.size(), 32'd0);

        // 5. Reset mid-load
        use4      = 1'b0;
        exp_count = 0;
        pulse_start();
        send(16'hAAAA);
        send(16'hBBBB);
        send(16'hCCCC);
        in_valid = 1'b0;
        in_data  = 'x;
        reset    = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check32("s5_reset", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        check("s5_mem", {15'd0, we32, addr32}, 32'd0);
        check("s5_wdata", {16'd0, wdata32}, 32'd0);
        check("s5_pending", q32.size(), 32'd0);
        exp_count = 0;
        pulse_start();
        send(16'hFFFF);
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clock);
        check32("s5_run", 1'b0, 1'b0, 1'b1, 1'b0, 6'd1);

        // 6. Restart from RUN, then a start pulse during LOAD
        pulse_start();
        check32("s6_restart", 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        pulse_start();
        check32("s6_start_in_load", 1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
        check("s6_no_write", {31'd0, we32}, 32'd0);
        exp_count = 0;
        send(16'h1234);
        send(16'hFFFF);
        in_valid = 1'b0;
        in_data  = 'x;
        @(negedge clock);
        check32("s6_run", 1'b0, 1'b0, 1'b1, 1'b0, 6'd2);
        @(negedge clock);
        check("final_pending32", q32.size(), 32'd0);
        check("final_pending4", q4.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
